// File: rtl/pipeline_pkg.sv
// Shared pipeline widths and control-bundle bit positions for the ID/EX boundary.
package pipeline_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CTRL_W     = 12;
    localparam int unsigned REG_ADDR_W = 5;

    localparam int unsigned CTRL_REGWRITE  = 0;
    localparam int unsigned CTRL_MEMREAD   = 1;
    localparam int unsigned CTRL_MEMWRITE  = 2;
    localparam int unsigned CTRL_ALUSRC    = 3;
    localparam int unsigned CTRL_ALUOP_LSB = 4;
    localparam int unsigned CTRL_ALUOP_MSB = 7;
    localparam int unsigned CTRL_REGDST    = 8;
    localparam int unsigned CTRL_MEMTOREG  = 9;

endpackage

// File: rtl/sat_counter.sv
// Increment-enable counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != MAX_VAL)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with valid/ready back-pressure, flush-to-bubble and
// a saturating bubble counter.
module id_ex_register #(
    parameter int unsigned DATA_W = pipeline_pkg::DATA_W,
    parameter int unsigned CTRL_W = pipeline_pkg::CTRL_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 id_valid,
    output logic                                 id_ready,
    input  logic                                 flush,
    input  logic [DATA_W-1:0]                    pc4_in,
    input  logic [DATA_W-1:0]                    reg_a_in,
    input  logic [DATA_W-1:0]                    reg_b_in,
    input  logic [DATA_W-1:0]                    imm_in,
    input  logic [pipeline_pkg::REG_ADDR_W-1:0]  rs_in,
    input  logic [pipeline_pkg::REG_ADDR_W-1:0]  rt_in,
    input  logic [pipeline_pkg::REG_ADDR_W-1:0]  rd_in,
    input  logic [CTRL_W-1:0]                    ctrl_in,
    output logic                                 ex_valid,
    input  logic                                 ex_ready,
    output logic [DATA_W-1:0]                    pc4_out,
    output logic [DATA_W-1:0]                    reg_a_out,
    output logic [DATA_W-1:0]                    reg_b_out,
    output logic [DATA_W-1:0]                    imm_out,
    output logic [pipeline_pkg::REG_ADDR_W-1:0]  rs_out,
    output logic [pipeline_pkg::REG_ADDR_W-1:0]  rt_out,
    output logic [pipeline_pkg::REG_ADDR_W-1:0]  rd_out,
    output logic [CTRL_W-1:0]                    ctrl_out,
    output logic [CNT_W-1:0]                     bubble_count
);

    import pipeline_pkg::*;

    logic load;
    logic bubble;

    // Slot is free when empty or being drained this cycle; flush never blocks ID.
    assign id_ready = ex_ready | ~ex_valid;
    assign load     = ~flush & id_ready & id_valid;
    assign bubble   = flush | (id_ready & ~id_valid);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid  <= 1'b0;
            pc4_out   <= '0;
            reg_a_out <= '0;
            reg_b_out <= '0;
            imm_out   <= '0;
            rs_out    <= '0;
            rt_out    <= '0;
            rd_out    <= '0;
            ctrl_out  <= '0;
        end else if (flush) begin
            ex_valid  <= 1'b0;
            pc4_out   <= '0;
            reg_a_out <= '0;
            reg_b_out <= '0;
            imm_out   <= '0;
            rs_out    <= '0;
            rt_out    <= '0;
            rd_out    <= '0;
            ctrl_out  <= '0;
        end else if (load) begin
            ex_valid  <= 1'b1;
            pc4_out   <= pc4_in;
            reg_a_out <= reg_a_in;
            reg_b_out <= reg_b_in;
            imm_out   <= imm_in;
            rs_out    <= rs_in;
            rt_out    <= rt_in;
            rd_out    <= rd_in;
            ctrl_out  <= ctrl_in;
        end else if (id_ready) begin
            // Drained with nothing behind it: control cleared so the bubble is inert.
            ex_valid  <= 1'b0;
            ctrl_out  <= '0;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_bubble_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (bubble),
        .count   (bubble_count)
    );

endmodule

// File: doc/id_ex_register.md
Name: id_ex_register

Overview:
- Pipeline register between the ID stage (register file read and SignExtend) and the EX stage.
- Captures the 32-bit extended immediate, both register operands, register specifiers, PC+4 and the control bundle, then presents them to EX one cycle later.
- Supports valid/ready back-pressure from a multi-cycle EX unit, hazard-unit flush (bubble insertion), and a saturating bubble counter for performance debug.

Parameters:
- DATA_W, 32, width of operands, immediate and PC+4.
- CTRL_W, 12, width of the decoded control bundle (RegWrite, MemRead, MemWrite, ALUSrc, ALUOp, RegDst, MemToReg, ...).
- CNT_W, 16, width of bubble_count.

Ports:
- clock  in  1  system clock, rising-edge active.
- reset_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID presents a valid instruction this cycle.
- id_ready  out  1  register can accept an ID instruction this cycle.
- flush  in  1  hazard/branch kill; forces a bubble.
- pc4_in  in  DATA_W  PC+4 of the ID instruction.
- reg_a_in  in  DATA_W  rs read data.
- reg_b_in  in  DATA_W  rt read data.
- imm_in  in  DATA_W  immediate already extended by SignExtend.
- rs_in, rt_in, rd_in  in  5 each  register specifiers.
- ctrl_in  in  CTRL_W  decoded control bundle.
- ex_valid  out  1  EX-side payload is valid.
- ex_ready  in  1  EX consumes the payload this cycle.
- pc4_out, reg_a_out, reg_b_out, imm_out  out  DATA_W each  registered payload.
- rs_out, rt_out, rd_out  out  5 each  registered specifiers.
- ctrl_out  out  CTRL_W  registered control; all-zero whenever ex_valid=0.
- bubble_count  out  CNT_W  saturating count of bubbles issued to EX.

Behaviour:
- Reset: asynchronous on reset_n=0. All payload outputs 0, ctrl_out 0, ex_valid 0, bubble_count 0. Reset mid-operation discards the held entry immediately, with no completion.
- id_ready is combinational: ex_ready OR NOT ex_valid. flush does not affect id_ready.
- Transfer: an ID instruction is accepted on a rising edge when id_valid=1, id_ready=1 and flush=0. Latency is 1 cycle; the payload appears on the outputs after that edge.
- Per-edge priority:
  1. flush=1: ex_valid<=0 and ctrl_out<=0. Other payload fields are also zeroed. This applies regardless of ex_ready and id_valid; the ID instruction offered that cycle is dropped, and upstream is responsible for re-fetch.
  2. else id_ready=1 and id_valid=1: load all *_in fields, ex_valid<=1.
  3. else id_ready=1 and id_valid=0: ex_valid<=0, ctrl_out<=0. Other payload fields hold.
  4. else (ex_valid=1, ex_ready=0): hold all outputs unchanged (stall).
- Simultaneous consume and load (ex_valid=1, ex_ready=1, id_valid=1): new payload replaces old in the same edge, giving a back-to-back throughput of 1 per cycle.
- Invariant: ex_valid=0 implies ctrl_out=0, so no RegWrite or MemWrite leaks from a bubble.
- bubble_count increments by 1 on an edge where ex_valid goes to or stays at 0 because of rule 1 or rule 3. It saturates at 2^CNT_W-1 with no wrap, and is cleared only by reset.
- imm_out is passed through unchanged; this block does no extension. Example: imm_in=32'hFFFF_FFF6 gives imm_out=32'hFFFF_FFF6.

Decomposition:
- Shared package (pipeline_pkg): DATA_W, CTRL_W, REG_ADDR_W=5, and the control-bundle bit positions as named constants (CTRL_REGWRITE, CTRL_MEMREAD, CTRL_MEMWRITE, CTRL_ALUSRC, CTRL_ALUOP msb/lsb, CTRL_REGDST, CTRL_MEMTOREG).
- One natural sub-module: sat_counter, a parameterised width, increment-enable, saturating counter used for bubble_count.

Test Plan:
- Reset: hold reset_n=0, drive all inputs non-zero -> all outputs 0, ex_valid=0, id_ready=1. Release, then pulse reset_n low mid-stall -> outputs 0 asynchronously, before the next edge.
- Basic transfer: ex_ready=1, id_valid=1, imm_in=32'h0000_000A, ctrl_in=12'h0A5 -> one cycle later ex_valid=1, imm_out=32'h0000_000A, ctrl_out=12'h0A5.
- Stall: entry valid with imm=32'hFFFF_FFF5, ex_ready=0 for 3 cycles while new inputs change -> outputs frozen, id_ready=0. Drop to ex_ready=1 -> next entry loads on the following edge.
- Flush priority: ex_valid=1, ex_ready=0, flush=1, id_valid=1 -> next cycle ex_valid=0, ctrl_out=0, bubble_count +1.
- Back-to-back: 4 consecutive valid instructions (imm 10, 0, 11, -1) with ex_ready=1 -> emitted on consecutive cycles in order, bubble_count unchanged.
- Counter saturation: with CNT_W=4, idle (id_valid=0) for 20 cycles -> bubble_count stops at 15.
